// File: rtl/ahb3lite_plic_cfg_seq_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_plic_cfg_seq_pkg
//   AHB3-Lite encodings shared by the PLIC boot configuration sequencer, its
//   bus interface and anything else in this slice that talks AHB3-Lite.
//   No ports; import with `import ahb3lite_plic_cfg_seq_pkg::*;`.
// ----------------------------------------------------------------------------
package ahb3lite_plic_cfg_seq_pkg;

  // HTRANS encodings (only IDLE and NONSEQ are ever driven by this master)
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE / HBURST / HPROT values used by the sequencer
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_plic_cfg_seq_if.sv
// ----------------------------------------------------------------------------
// ahb3lite_plic_cfg_seq_if
//   AHB3-Lite master/slave signal bundle used by the PLIC configuration
//   sequencer. The clock and reset stay outside the interface.
//   master modport : drives HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/
//                    HTRANS/HMASTLOCK, samples HRDATA/HREADY/HRESP
//   slave modport  : the mirror image
// ----------------------------------------------------------------------------
interface ahb3lite_plic_cfg_seq_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);

  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb3lite_plic_cfg_seq.sv
// ----------------------------------------------------------------------------
// ahb3lite_plic_cfg_seq
//   Boot-time AHB3-Lite master that walks an external table of
//   (address, data, mask) entries and writes each one into the PLIC with a
//   single-word transfer, optionally reading it back and comparing under the
//   mask. busy/done/error let the platform hold the harts until the PLIC is
//   configured.
//
// Ports
//   HCLK, HRESETn         clock (rising edge), synchronous active-low reset
//   start                 begin a sequence (ignored while busy)
//   busy, done, error     status; done is a level, error is sticky until the
//                         next accepted start
//   err_idx               table index of the failing entry
//   tbl_idx               table index being looked up
//   tbl_valid/addr/data/mask  combinational table lookup at tbl_idx
//   ahb                   AHB3-Lite master port
// ----------------------------------------------------------------------------
module ahb3lite_plic_cfg_seq
  import ahb3lite_plic_cfg_seq_pkg::*;
#(
  parameter  int HADDR_SIZE = 32,
  parameter  int HDATA_SIZE = 32,
  parameter  int ENTRIES    = 16,
  parameter  int VERIFY     = 1,
  localparam int IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_idx,

  output logic [IDX_W-1:0]      tbl_idx,
  input  logic                  tbl_valid,
  input  logic [HADDR_SIZE-1:0] tbl_addr,
  input  logic [HDATA_SIZE-1:0] tbl_data,
  input  logic [HDATA_SIZE-1:0] tbl_mask,

  ahb3lite_plic_cfg_seq_if.master ahb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WADDR,
    S_WDATA,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t                state;
  logic [HDATA_SIZE-1:0] ent_data;
  logic [HDATA_SIZE-1:0] ent_mask;

  logic [1:0]            htrans_r;
  logic                  hwrite_r;
  logic [HADDR_SIZE-1:0] haddr_r;
  logic [HDATA_SIZE-1:0] hwdata_r;

  logic                  last_entry;
  logic                  rd_mismatch;

  assign last_entry  = (tbl_idx == IDX_W'(ENTRIES - 1));
  assign rd_mismatch = |((ahb.HRDATA ^ ent_data) & ent_mask);

  // Constant transfer attributes; HSEL simply follows the active transfer.
  assign ahb.HTRANS    = htrans_r;
  assign ahb.HWRITE    = hwrite_r;
  assign ahb.HADDR     = haddr_r;
  assign ahb.HWDATA    = hwdata_r;
  assign ahb.HSEL      = (htrans_r == HTRANS_NONSEQ);
  assign ahb.HSIZE     = HSIZE_WORD;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_DATA_PRIV;
  assign ahb.HMASTLOCK = 1'b0;

  // The table value registers are pure data and need no reset; they are
  // only read after FETCH has loaded them.
  always_ff @(posedge HCLK) begin
    if (state == S_FETCH && tbl_valid) begin
      ent_data <= tbl_data;
      ent_mask <= tbl_mask;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_idx  <= '0;
      tbl_idx  <= '0;
      htrans_r <= HTRANS_IDLE;
      hwrite_r <= 1'b0;
      haddr_r  <= '0;
      hwdata_r <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_FETCH;
            tbl_idx <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
          end
        end

        S_FETCH: begin
          if (!tbl_valid) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // HADDR keeps the entry address for both the write and the
            // readback, so it doubles as the latched address.
            state    <= S_WADDR;
            htrans_r <= HTRANS_NONSEQ;
            hwrite_r <= 1'b1;
            haddr_r  <= tbl_addr;
          end
        end

        S_WADDR: begin
          if (ahb.HREADY) begin
            state    <= S_WDATA;
            htrans_r <= HTRANS_IDLE;
            hwdata_r <= ent_data;
          end
        end

        // The first ERROR cycle has HREADY=0 and we already drive IDLE, so
        // the decision waits for the HREADY=1 cycle.
        S_WDATA: begin
          if (ahb.HREADY) begin
            if (ahb.HRESP == HRESP_ERROR) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= 1'b1;
              err_idx <= tbl_idx;
            end else if (VERIFY != 0) begin
              state    <= S_RADDR;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b0;
            end else if (last_entry) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              tbl_idx <= tbl_idx + IDX_W'(1);
            end
          end
        end

        S_RADDR: begin
          if (ahb.HREADY) begin
            state    <= S_RDATA;
            htrans_r <= HTRANS_IDLE;
          end
        end

        S_RDATA: begin
          if (ahb.HREADY) begin
            if (ahb.HRESP == HRESP_ERROR || rd_mismatch) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= 1'b1;
              err_idx <= tbl_idx;
            end else if (last_entry) begin
              // Table exhausted: stop without wrapping the index.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              tbl_idx <= tbl_idx + IDX_W'(1);
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          htrans_r <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_plic_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_ahb3lite_plic_cfg_seq
//   Directed bench for the PLIC configuration sequencer with a small AHB
//   slave model (programmable wait states, two-cycle ERROR on one address,
//   readback corruption on one address) and a bus transfer monitor.
// ----------------------------------------------------------------------------
module tb_ahb3lite_plic_cfg_seq;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              start;
  logic              busy, done, error;
  logic [IDX_W-1:0]  err_idx, tbl_idx;
  logic              tbl_valid;
  logic [31:0]       tbl_addr, tbl_data, tbl_mask;

  ahb3lite_plic_cfg_seq_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

  ahb3lite_plic_cfg_seq #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .ENTRIES(ENTRIES), .VERIFY(1)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx),
    .tbl_idx   (tbl_idx),
    .tbl_valid (tbl_valid),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .tbl_mask  (tbl_mask),
    .ahb       (bus.master)
  );

  always #5 HCLK = ~HCLK;

  // Table storage
  logic [31:0] t_a [ENTRIES];
  logic [31:0] t_d [ENTRIES];
  logic [31:0] t_m [ENTRIES];
  logic        t_v [ENTRIES];

  assign tbl_valid = t_v[tbl_idx];
  assign tbl_addr  = t_a[tbl_idx];
  assign tbl_data  = t_d[tbl_idx];
  assign tbl_mask  = t_m[tbl_idx];

  // Slave model
  int          wait_n = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic        cor_en = 1'b0;
  logic [31:0] cor_addr = '0, cor_val = '0;
  logic        dphase, dwrite;
  logic [31:0] daddr, wlast;
  int          wcnt;

  always_comb begin
    bus.HRESP  = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRDATA = wlast;
    if (dphase) begin
      if (err_en && dwrite && daddr == err_addr) begin
        bus.HRESP  = 1'b1;
        bus.HREADY = (wcnt >= 1);
      end else begin
        bus.HREADY = (wcnt >= wait_n);
      end
      if (cor_en && !dwrite && daddr == cor_addr) bus.HRDATA = cor_val;
    end else if (bus.HTRANS == 2'b10) begin
      bus.HREADY = (wcnt >= wait_n);
    end
  end

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dphase <= 1'b0;
      dwrite <= 1'b0;
      daddr  <= '0;
      wlast  <= '0;
      wcnt   <= 0;
    end else if (bus.HREADY) begin
      wcnt <= 0;
      if (dphase && dwrite && !bus.HRESP) wlast <= bus.HWDATA;
      dphase <= (bus.HTRANS == 2'b10);
      dwrite <= bus.HWRITE;
      daddr  <= bus.HADDR;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Bus monitor (sampled mid-cycle)
  logic        log_w [$];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  int          pipe_err = 0, stab_err = 0;
  logic        prev_acc = 1'b0, stall_prev = 1'b0, wd_prev = 1'b0;
  logic [1:0]  p_t;
  logic [31:0] p_a, p_d;
  logic        p_w;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (stall_prev && (bus.HTRANS != p_t || bus.HADDR != p_a || bus.HWRITE != p_w))
        stab_err++;
      if (wd_prev && bus.HWDATA != p_d) stab_err++;
      stall_prev = (bus.HTRANS == 2'b10) && !bus.HREADY;
      wd_prev    = dphase && dwrite && !bus.HREADY;
      p_t = bus.HTRANS; p_a = bus.HADDR; p_w = bus.HWRITE; p_d = bus.HWDATA;
      if (bus.HREADY) begin
        if (bus.HTRANS == 2'b10) begin
          if (prev_acc) pipe_err++;
          log_w.push_back(bus.HWRITE);
          log_a.push_back(bus.HADDR);
        end
        prev_acc = (bus.HTRANS == 2'b10);
        if (dphase && dwrite && !bus.HRESP) log_d.push_back(bus.HWDATA);
      end
    end else begin
      stall_prev = 1'b0;
      wd_prev    = 1'b0;
      prev_acc   = 1'b0;
    end
  end

  // Checking
  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_log();
    log_w.delete();
    log_a.delete();
    log_d.delete();
  endtask

  // Start a sequence; optionally pulse start again (while busy) at kick_at.
  task automatic run_seq(input int kick_at, output int cyc);
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (cyc == kick_at) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
  endtask

  // Expected bus order: entry k write then entry k read, n_xfer transfers in
  // total; n_data write data phases completed with OKAY.
  task automatic check_xfers(input string t, input int n_xfer, input int n_data);
    check({t, "_nxfer"}, 32'(log_a.size()), 32'(n_xfer));
    check({t, "_ndata"}, 32'(log_d.size()), 32'(n_data));
    for (int k = 0; k < n_xfer && k < log_a.size(); k++) begin
      check($sformatf("%s_addr%0d", t, k), log_a[k], t_a[k/2]);
      check($sformatf("%s_wr%0d", t, k), 32'(log_w[k]), 32'((k % 2) == 0));
    end
    for (int k = 0; k < n_data && k < log_d.size(); k++)
      check($sformatf("%s_wdata%0d", t, k), log_d[k], t_d[k]);
  endtask

  task automatic load3();
    for (int i = 0; i < ENTRIES; i++) begin
      t_a[i] = '0; t_d[i] = '0; t_m[i] = '0; t_v[i] = 1'b0;
    end
    t_a[0] = 32'h0000_0004; t_d[0] = 32'h0000_0007; t_m[0] = 32'hFFFF_FFFF; t_v[0] = 1'b1;
    t_a[1] = 32'h0000_2000; t_d[1] = 32'hFFFF_FFFF; t_m[1] = 32'hFFFF_FFFF; t_v[1] = 1'b1;
    t_a[2] = 32'h0020_0000; t_d[2] = 32'h0000_0001; t_m[2] = 32'hFFFF_FFFF; t_v[2] = 1'b1;
  endtask

  int cyc;
  int guard;

  initial begin
    start   = 1'b0;
    HRESETn = 1'b0;
    load3();
    repeat (3) tick();
    HRESETn = 1'b1;
    tick();

    // Reset state and constant attributes
    check("rst_busy",   32'(busy),          32'd0);
    check("rst_done",   32'(done),          32'd0);
    check("rst_error",  32'(error),         32'd0);
    check("rst_erridx", 32'(err_idx),       32'd0);
    check("rst_tblidx", 32'(tbl_idx),       32'd0);
    check("rst_htrans", 32'(bus.HTRANS),    32'd0);
    check("rst_hwrite", 32'(bus.HWRITE),    32'd0);
    check("rst_haddr",  bus.HADDR,          32'd0);
    check("rst_hwdata", bus.HWDATA,         32'd0);
    check("rst_hsel",   32'(bus.HSEL),      32'd0);
    check("hsize",      32'(bus.HSIZE),     32'd2);
    check("hburst",     32'(bus.HBURST),    32'd0);
    check("hprot",      32'(bus.HPROT),     32'd3);
    check("hmastlock",  32'(bus.HMASTLOCK), 32'd0);

    // 1: three entries, zero-wait; extra start pulse while busy is ignored
    wait_n = 0;
    run_seq(5, cyc);
    check("t1_cycles", 32'(cyc),     32'd17);
    check("t1_done",   32'(done),    32'd1);
    check("t1_busy",   32'(busy),    32'd0);
    check("t1_error",  32'(error),   32'd0);
    check("t1_tblidx", 32'(tbl_idx), 32'd3);
    check_xfers("t1", 6, 3);

    // 2: two wait states on every phase
    wait_n = 2;
    run_seq(0, cyc);
    check("t2_done",  32'(done),  32'd1);
    check("t2_error", 32'(error), 32'd0);
    check_xfers("t2", 6, 3);
    check("t2_stable", 32'(stab_err), 32'd0);
    wait_n = 0;

    // 3: readback of entry 1 returns 0x5 against 0x7 under mask 0x7
    t_d[1] = 32'h0000_0007; t_m[1] = 32'h0000_0007;
    cor_en = 1'b1; cor_addr = 32'h0000_2000; cor_val = 32'h0000_0005;
    run_seq(0, cyc);
    check("t3_error",  32'(error),   32'd1);
    check("t3_erridx", 32'(err_idx), 32'd1);
    check("t3_done",   32'(done),    32'd1);
    check_xfers("t3", 4, 2);
    t_m[1] = 32'h0000_0000;
    run_seq(0, cyc);
    check("t3m0_error", 32'(error), 32'd0);
    check("t3m0_done",  32'(done),  32'd1);
    check_xfers("t3m0", 6, 3);
    cor_en = 1'b0;
    load3();

    // 4: two-cycle ERROR on the entry 0 write, then a clean rerun
    err_en = 1'b1; err_addr = 32'h0000_0004;
    run_seq(0, cyc);
    check("t4_error",  32'(error),   32'd1);
    check("t4_erridx", 32'(err_idx), 32'd0);
    check("t4_done",   32'(done),    32'd1);
    check_xfers("t4", 1, 0);
    repeat (4) tick();
    check("t4_quiet", 32'(log_a.size()), 32'd1);
    err_en = 1'b0;
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_errclr",  32'(error), 32'd0);
    check("t4_doneclr", 32'(done),  32'd0);
    check("t4_busy",    32'(busy),  32'd1);
    guard = 0;
    while (!done && guard < 2000) begin tick(); guard++; end
    check("t4_rerun_error", 32'(error), 32'd0);
    check("t4_rerun_done",  32'(done),  32'd1);
    check_xfers("t4r", 6, 3);

    // 5a: empty table
    t_v[0] = 1'b0;
    run_seq(0, cyc);
    check("t5a_cycles", 32'(cyc),          32'd2);
    check("t5a_done",   32'(done),         32'd1);
    check("t5a_nxfer",  32'(log_a.size()), 32'd0);

    // 5b: every entry valid, stops at ENTRIES-1 without wrapping
    for (int i = 0; i < ENTRIES; i++) begin
      t_a[i] = 32'(i * 4); t_d[i] = 32'(i + 16); t_m[i] = 32'hFFFF_FFFF; t_v[i] = 1'b1;
    end
    run_seq(0, cyc);
    check("t5b_cycles", 32'(cyc),     32'd81);
    check("t5b_done",   32'(done),    32'd1);
    check("t5b_error",  32'(error),   32'd0);
    check("t5b_tblidx", 32'(tbl_idx), 32'd15);
    check_xfers("t5b", 32, 16);
    load3();

    // 6: reset during the entry 2 write data phase
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(tbl_idx == 2 && bus.HTRANS == 2'b10 && bus.HWRITE) && guard < 200) begin
      tick(); guard++;
    end
    check("t6_reach_waddr2", 32'(guard < 200), 32'd1);
    tick();
    HRESETn = 1'b0;
    tick();
    check("t6_busy",   32'(busy),        32'd0);
    check("t6_done",   32'(done),        32'd0);
    check("t6_htrans", 32'(bus.HTRANS),  32'd0);
    check("t6_tblidx", 32'(tbl_idx),     32'd0);
    HRESETn = 1'b1;
    clear_log();
    repeat (6) tick();
    check("t6_quiet",  32'(log_a.size()), 32'd0);
    check("t6_done2",  32'(done),         32'd0);

    check("pipeline", 32'(pipe_err), 32'd0);
    check("stability", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
